// File: rtl/event_ctl_array.sv
`default_nettype none
// ----------------------------------------------------------------------
// event_ctl_array : per-channel event-gated bitwise results with a
//                   coalescing valid/ready event report.   Rev 1.0
// ----------------------------------------------------------------------
module event_ctl_array #(
  parameter int WIDTH = 4,
  parameter int NCH   = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] a,
  input  logic [NCH*WIDTH-1:0] b,
  input  logic [NCH*WIDTH-1:0] c,
  input  logic                 full_sens,
  input  logic [1:0]           y_op,
  input  logic                 force_upd,
  output logic [NCH*WIDTH-1:0] x_part,
  output logic [NCH*WIDTH-1:0] y_part,
  output logic                 evt_valid,
  output logic [NCH-1:0]       evt_mask,
  input  logic                 evt_ready,
  output logic [CNT_W-1:0]     evt_cnt,
  output logic [CNT_W-1:0]     coal_cnt
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NCH*WIDTH-1:0] a_q, b_q, c_q;
  logic [NCH*WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [NCH-1:0]       ev;
  logic [NCH-1:0]       mask_q, mask_d;
  logic [CNT_W-1:0]     evt_cnt_q, evt_cnt_d;
  logic [CNT_W-1:0]     coal_cnt_q, coal_cnt_d;
  logic                 any_ev;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] a_i, b_i, c_i, y_new;

    assign a_i = a[i*WIDTH +: WIDTH];
    assign b_i = b[i*WIDTH +: WIDTH];
    assign c_i = c[i*WIDTH +: WIDTH];

    // c only participates when full sensitivity is selected
    assign ev[i] = (a_i != a_q[i*WIDTH +: WIDTH])
                 | (b_i != b_q[i*WIDTH +: WIDTH])
                 | (full_sens & (c_i != c_q[i*WIDTH +: WIDTH]))
                 | force_upd;

    always_comb begin
      y_new = '0;
      case (y_op)
        2'b00:   y_new = (b_i | c_i) ^ a_i;
        2'b01:   y_new = (b_i & c_i) ^ a_i;
        2'b10:   y_new = a_i ^ b_i ^ c_i;
        default: y_new = ~((b_i | c_i) ^ a_i);
      endcase
    end

    assign x_d[i*WIDTH +: WIDTH] = ev[i] ? (a_i & b_i & c_i) : x_q[i*WIDTH +: WIDTH];
    assign y_d[i*WIDTH +: WIDTH] = ev[i] ? y_new : y_q[i*WIDTH +: WIDTH];
  end

  assign any_ev = |ev;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    coal_cnt_d = coal_cnt_q;
    evt_cnt_d  = any_ev ? evt_cnt_q + CNT_W'(1) : evt_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_ev) begin
          state_d = S_PEND;
          mask_d  = ev;
        end
      end
      S_PEND: begin
        if (evt_ready) begin
          if (any_ev) begin
            mask_d = ev;
          end else begin
            state_d = S_IDLE;
            mask_d  = '0;
          end
        end else begin
          // Report is stalled: fold new events in so nothing is lost
          mask_d = mask_q | ev;
          if (any_ev && (coal_cnt_q != '1)) begin
            coal_cnt_d = coal_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        mask_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      mask_q     <= '0;
      evt_cnt_q  <= '0;
      coal_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a;
      b_q        <= b;
      c_q        <= c;
      x_q        <= x_d;
      y_q        <= y_d;
      mask_q     <= mask_d;
      evt_cnt_q  <= evt_cnt_d;
      coal_cnt_q <= coal_cnt_d;
    end
  end

  assign x_part    = x_q;
  assign y_part    = y_q;
  assign evt_valid = (state_q == S_PEND);
  assign evt_mask  = mask_q;
  assign evt_cnt   = evt_cnt_q;
  assign coal_cnt  = coal_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_event_ctl_array.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_event_ctl_array : directed + random bench with a behavioural model.
//                      Rev 1.0
// ----------------------------------------------------------------------
module tb_event_ctl_array;

  localparam int WIDTH = 4;
  localparam int NCH   = 2;
  localparam int CNT_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] a, b, c;
  logic                 full_sens, force_upd, evt_ready;
  logic [1:0]           y_op;
  logic [NCH*WIDTH-1:0] x_part, y_part;
  logic                 evt_valid;
  logic [NCH-1:0]       evt_mask;
  logic [CNT_W-1:0]     evt_cnt, coal_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  event_ctl_array #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .full_sens (full_sens),
    .y_op      (y_op),
    .force_upd (force_upd),
    .x_part    (x_part),
    .y_part    (y_part),
    .evt_valid (evt_valid),
    .evt_mask  (evt_mask),
    .evt_ready (evt_ready),
    .evt_cnt   (evt_cnt),
    .coal_cnt  (coal_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural reference state, one entry per channel
  int m_x[NCH], m_y[NCH], pa[NCH], pb[NCH], pc[NCH];
  bit m_valid;
  bit m_mask[NCH];
  int m_evt, m_coal;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int field(input logic [NCH*WIDTH-1:0] v, input int ch);
    logic [NCH*WIDTH-1:0] t;
    t = v >> (ch*WIDTH);
    return int'(t[WIDTH-1:0]);
  endfunction

  function automatic int yfun(input int op, input int av, input int bv, input int cv);
    int r;
    case (op)
      0:       r = (bv | cv) ^ av;
      1:       r = (bv & cv) ^ av;
      2:       r = av ^ bv ^ cv;
      default: r = 15 - ((bv | cv) ^ av);
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_x[i] = 0; m_y[i] = 0; pa[i] = 0; pb[i] = 0; pc[i] = 0; m_mask[i] = 0;
    end
    m_valid = 0; m_evt = 0; m_coal = 0;
  endtask

  task automatic model_clock();
    bit evs[NCH];
    bit any;
    any = 0;
    for (int i = 0; i < NCH; i++) begin
      int av, bv, cv;
      av = field(a, i); bv = field(b, i); cv = field(c, i);
      evs[i] = (av != pa[i]) || (bv != pb[i]) || (full_sens && cv != pc[i]) || force_upd;
      if (evs[i]) begin
        m_x[i] = av & bv & cv;
        m_y[i] = yfun(int'(y_op), av, bv, cv);
        any = 1;
      end
      pa[i] = av; pb[i] = bv; pc[i] = cv;
    end
    if (!m_valid) begin
      if (any) begin m_valid = 1; m_mask = evs; end
    end else if (evt_ready) begin
      if (any) m_mask = evs;
      else begin m_valid = 0; for (int i = 0; i < NCH; i++) m_mask[i] = 0; end
    end else begin
      for (int i = 0; i < NCH; i++) m_mask[i] = m_mask[i] | evs[i];
      if (any && m_coal < 255) m_coal++;
    end
    if (any) m_evt = (m_evt + 1) % 256;
  endtask

  task automatic check_all();
    logic [NCH*WIDTH-1:0] ex, ey;
    logic [NCH-1:0] em;
    for (int i = 0; i < NCH; i++) begin
      ex[i*WIDTH +: WIDTH] = WIDTH'(m_x[i]);
      ey[i*WIDTH +: WIDTH] = WIDTH'(m_y[i]);
      em[i] = m_mask[i];
    end
    chk("x_part",    64'(x_part),    64'(ex));
    chk("y_part",    64'(y_part),    64'(ey));
    chk("evt_valid", 64'(evt_valid), 64'(m_valid));
    chk("evt_mask",  64'(evt_mask),  64'(em));
    chk("evt_cnt",   64'(evt_cnt),   64'(m_evt));
    chk("coal_cnt",  64'(coal_cnt),  64'(m_coal));
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; a = '0; b = '0; c = '0;
    full_sens = 1'b0; y_op = 2'b00; force_upd = 1'b0; evt_ready = 1'b1;
    model_reset();
    #12;
    check_all();
    @(negedge clk); rst_n = 1'b1;

    // Quiet inputs: no events
    repeat (3) step();
    chk("idle_cnt", 64'(evt_cnt), 64'd0);

    // Partial mode, ch0 update
    a = 8'h0F; b = 8'h03; c = 8'h05;
    step();
    chk("tp_x0", 64'(x_part[3:0]), 64'h1);
    chk("tp_y0", 64'(y_part[3:0]), 64'h8);
    chk("tp_mask", 64'(evt_mask), 64'h1);
    chk("tp_cnt", 64'(evt_cnt), 64'h1);
    c = 8'h0A;
    step();
    chk("stale_x0", 64'(x_part[3:0]), 64'h1);
    chk("stale_valid", 64'(evt_valid), 64'h0);

    // Full mode, c-only change
    c = 8'h05; step();
    full_sens = 1'b1; c = 8'h0A;
    step();
    chk("full_x0", 64'(x_part[3:0]), 64'h2);
    chk("full_y0", 64'(y_part[3:0]), 64'h4);
    chk("full_mask", 64'(evt_mask), 64'h1);
    step();

    // Coalescing with consumer stalled
    evt_ready = 1'b0;
    a = 8'h0E; step();
    step();
    a = 8'h1E; step();
    chk("coal_mask", 64'(evt_mask), 64'h3);
    chk("coal_valid", 64'(evt_valid), 64'h1);
    chk("coal_cnt1", 64'(coal_cnt), 64'h1);
    evt_ready = 1'b1; step();
    step();
    chk("drain_valid", 64'(evt_valid), 64'h0);

    // y_op sweep with force pulses
    a = 8'h66; b = 8'h33; c = 8'h44; step();
    for (int op = 0; op < 4; op++) begin
      logic [3:0] exp_y [4];
      exp_y[0] = 4'h1; exp_y[1] = 4'h6; exp_y[2] = 4'h1; exp_y[3] = 4'hE;
      y_op = 2'(op); force_upd = 1'b1;
      step();
      force_upd = 1'b0;
      chk("sweep_y", 64'(y_part), 64'({exp_y[op], exp_y[op]}));
      chk("sweep_mask", 64'(evt_mask), 64'h3);
    end
    step();

    // Async reset while a ch1 report is pending
    evt_ready = 1'b0; b = 8'h53; step();
    chk("pre_rst_mask", 64'(evt_mask), 64'h2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_valid", 64'(evt_valid), 64'h0);
    a = '0; b = '0; c = '0; full_sens = 1'b0; y_op = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    step();

    // Randomised phase: inputs mostly hold so sensitivity gating is exercised
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) a[$urandom_range(0, NCH-1)*WIDTH +: WIDTH] = 4'($urandom);
      if ($urandom_range(0, 3) == 0) b[$urandom_range(0, NCH-1)*WIDTH +: WIDTH] = 4'($urandom);
      if ($urandom_range(0, 2) == 0) c[$urandom_range(0, NCH-1)*WIDTH +: WIDTH] = 4'($urandom);
      if ($urandom_range(0, 15) == 0) full_sens = ~full_sens;
      if ($urandom_range(0, 7) == 0) y_op = 2'($urandom);
      force_upd = ($urandom_range(0, 19) == 0);
      evt_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
